mem_ctrl: RTL and testbench

Memory controller sitting directly downstream of the execute stage's data-memory port and alongside instruction fetch. Arbitrates between a fetch read port and an execute load/store port. Serialises each granted access into little-endian byte beats on a byte-wide req/ack memory bus, then returns assembled read data with a one-cycle ready pulse.

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl.sv | 140 ++++++++++++++
 tb/tb_mem_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared access-size codes, FSM states and owner encoding
package mem_ctrl_pkg;

  localparam logic [1:0] MEM_ACC_8  = 2'b00;
  localparam logic [1:0] MEM_ACC_16 = 2'b01;
  localparam logic [1:0] MEM_ACC_32 = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BEAT,
    ST_DONE,
    ST_RELEASE
  } state_t;

  typedef enum logic {
    OWN_EXEC,
    OWN_FETCH
  } owner_t;

  // Byte beats for an execute access, clipped to the client width in bytes.
  // Code 2'b11 is treated as a word, the same as MEM_ACC_32.
  function automatic int acc_beats(input logic [1:0] code, input int max_beats);
    int n;
    case (code)
      MEM_ACC_8:  n = 1;
      MEM_ACC_16: n = 2;
      default:    n = 4;
    endcase
    return (n > max_beats) ? max_beats : n;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - fetch/execute arbiter serialising accesses into byte beats
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int M_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [M_WIDTH-1:0] mem_addr,
  input  logic [M_WIDTH-1:0] mem_data_out,
  input  logic [1:0]         mem_acc_width,
  output logic [M_WIDTH-1:0] mem_data_in,
  output logic               mem_ready,
  input  logic               if_req,
  input  logic [M_WIDTH-1:0] if_addr,
  output logic [M_WIDTH-1:0] if_data,
  output logic               if_ready,
  output logic               bus_req,
  output logic               bus_we,
  output logic [M_WIDTH-1:0] bus_addr,
  output logic [7:0]         bus_wdata,
  input  logic [7:0]         bus_rdata,
  input  logic               bus_ack
);

  localparam int NB = M_WIDTH / 8;
  localparam int CW = $clog2(NB) + 1;

  state_t             r_state;
  owner_t             r_owner;
  logic [CW-1:0]      r_n;
  logic [CW-1:0]      r_idx;
  logic [M_WIDTH-1:0] r_shift;
  logic [M_WIDTH-1:0] r_mem_rdata;
  logic [M_WIDTH-1:0] r_if_rdata;
  logic               r_mem_ready;
  logic               r_if_ready;
  logic               r_bus_req;
  logic               r_bus_we;
  logic [M_WIDTH-1:0] r_bus_addr;
  logic [7:0]         r_bus_wdata;

  logic [CW-1:0]      w_idx_next;
  logic               w_last;
  logic               w_owner_req;

  assign w_idx_next  = r_idx + CW'(1);
  assign w_last      = (w_idx_next == r_n);
  assign w_owner_req = (r_owner == OWN_EXEC) ? mem_req : if_req;

  // Grant, beat sequencing, read assembly and ready pulse; all outputs registered.
  // r_shift holds the not-yet-sent store bytes so the next beat byte is always r_shift[7:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_EXEC;
      r_n         <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_mem_rdata <= '0;
      r_if_rdata  <= '0;
      r_mem_ready <= 1'b0;
      r_if_ready  <= 1'b0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_idx <= '0;
          if (mem_req) begin
            r_state     <= ST_BEAT;
            r_owner     <= OWN_EXEC;
            r_bus_req   <= 1'b1;
            r_bus_we    <= mem_we;
            r_bus_addr  <= mem_addr;
            r_bus_wdata <= mem_data_out[7:0];
            r_shift     <= mem_data_out >> 8;
            r_n         <= CW'(acc_beats(mem_acc_width, NB));
            if (!mem_we) r_mem_rdata <= '0;
          end else if (if_req) begin
            r_state     <= ST_BEAT;
            r_owner     <= OWN_FETCH;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= if_addr;
            r_bus_wdata <= '0;
            r_shift     <= '0;
            r_n         <= CW'(NB);
            r_if_rdata  <= '0;
          end
        end
        ST_BEAT: begin
          if (bus_ack) begin
            for (int b = 0; b < NB; b++) begin
              if (!r_bus_we && r_idx == CW'(b)) begin
                if (r_owner == OWN_EXEC) r_mem_rdata[b*8 +: 8] <= bus_rdata;
                else                     r_if_rdata[b*8 +: 8]  <= bus_rdata;
              end
            end
            r_idx       <= w_idx_next;
            r_bus_addr  <= r_bus_addr + M_WIDTH'(1);
            r_bus_wdata <= r_shift[7:0];
            r_shift     <= r_shift >> 8;
            if (w_last) begin
              r_state     <= ST_DONE;
              r_bus_req   <= 1'b0;
              r_bus_we    <= 1'b0;
              r_bus_wdata <= '0;
              if (r_owner == OWN_EXEC) r_mem_ready <= 1'b1;
              else                     r_if_ready  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_mem_ready <= 1'b0;
          r_if_ready  <= 1'b0;
          r_state     <= ST_RELEASE;
        end
        ST_RELEASE: begin
          if (!w_owner_req) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_data_in = r_mem_rdata;
  assign mem_ready   = r_mem_ready;
  assign if_data     = r_if_rdata;
  assign if_ready    = r_if_ready;
  assign bus_req     = r_bus_req;
  assign bus_we      = r_bus_we;
  assign bus_addr    = r_bus_addr;
  assign bus_wdata   = r_bus_wdata;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl at 8- and 32-bit widths
`timescale 1ns/1ps
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        mem_req, mem_we, if_req;
  logic [31:0] mem_addr, mem_data_out, if_addr;
  logic [1:0]  mem_acc_width;
  logic [31:0] mem_data_in, if_data, bus_addr;
  logic        mem_ready, if_ready, bus_req, bus_we;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = 8'h00;
  logic        bus_ack = 1'b0;

  logic        mem_req8, mem_we8, if_req8;
  logic [7:0]  mem_addr8, mem_data_out8, if_addr8;
  logic [1:0]  mem_acc_width8;
  logic [7:0]  mem_data_in8, if_data8, bus_addr8, bus_wdata8;
  logic        mem_ready8, if_ready8, bus_req8, bus_we8;
  logic [7:0]  bus_rdata8 = 8'h00;
  logic        bus_ack8 = 1'b0;

  mem_ctrl #(.M_WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
    .mem_acc_width(mem_acc_width), .mem_data_in(mem_data_in), .mem_ready(mem_ready),
    .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_ready(if_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  mem_ctrl #(.M_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8), .mem_data_out(mem_data_out8),
    .mem_acc_width(mem_acc_width8), .mem_data_in(mem_data_in8), .mem_ready(mem_ready8),
    .if_req(if_req8), .if_addr(if_addr8), .if_data(if_data8), .if_ready(if_ready8),
    .bus_req(bus_req8), .bus_we(bus_we8), .bus_addr(bus_addr8), .bus_wdata(bus_wdata8),
    .bus_rdata(bus_rdata8), .bus_ack(bus_ack8)
  );

  // 32-bit bus slave: byte memory, programmable ack wait, log of completed beats
  logic [7:0] mem32 [bit [31:0]];
  bit [31:0]  log_addr [$];
  bit [7:0]   log_wdata [$];
  bit         log_we [$];
  int         wait32 = 0;
  int         wcnt32 = 0;

  always @(posedge clk) begin
    if (!rst && bus_req && bus_ack) begin
      log_addr.push_back(bus_addr);
      log_wdata.push_back(bus_wdata);
      log_we.push_back(bus_we);
      wcnt32 = 0;
    end
    #1;
    if (bus_req && !rst) begin
      if (wcnt32 >= wait32) begin
        bus_ack   = 1'b1;
        bus_rdata = mem32.exists(bus_addr) ? mem32[bus_addr] : 8'h00;
      end else begin
        bus_ack = 1'b0;
        wcnt32++;
      end
    end else begin
      bus_ack = 1'b0;
      wcnt32  = 0;
    end
  end

  // 8-bit bus slave: zero-wait, always returns 0xA5
  int         beats8 = 0;
  logic [7:0] last_addr8 = 8'h00;
  logic [7:0] last_wdata8 = 8'h00;
  logic       last_we8 = 1'b0;

  always @(posedge clk) begin
    if (!rst && bus_req8 && bus_ack8) begin
      beats8++;
      last_addr8  = bus_addr8;
      last_wdata8 = bus_wdata8;
      last_we8    = bus_we8;
    end
    #1;
    bus_ack8   = bus_req8 && !rst;
    bus_rdata8 = 8'hA5;
  end

  int mem_rdy_cnt = 0;
  int if_rdy_cnt  = 0;
  always @(negedge clk) begin
    if (mem_ready) mem_rdy_cnt++;
    if (if_ready)  if_rdy_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // sel: 0 = 32-bit execute, 1 = 32-bit fetch, 2 = 8-bit execute; k = negedges until ready
  task automatic wait_rdy(input int sel, input int budget, output int k);
    logic r;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      r = (sel == 0) ? mem_ready : (sel == 1) ? if_ready : mem_ready8;
    end while (!r && k < budget);
  endtask

  task automatic release_exec();
    @(negedge clk);
    mem_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({bus_req, bus_we, mem_ready, if_ready} !== 4'b0) begin n_bad++; $display("FAIL reset_ctrl32: got %b expected 0000", {bus_req, bus_we, mem_ready, if_ready}); end
    n_cmp++; if (bus_addr !== 32'h0 || bus_wdata !== 8'h0) begin n_bad++; $display("FAIL reset_bus32: got addr %h wdata %h expected 0", bus_addr, bus_wdata); end
    n_cmp++; if (mem_data_in !== 32'h0 || if_data !== 32'h0) begin n_bad++; $display("FAIL reset_rdata32: got %h/%h expected 0", mem_data_in, if_data); end
    n_cmp++; if ({bus_req8, bus_we8, mem_ready8, if_ready8, bus_addr8, bus_wdata8, mem_data_in8, if_data8} !== 36'h0) begin n_bad++; $display("FAIL reset_all8: got %h expected 0", {bus_req8, bus_we8, mem_ready8, if_ready8, bus_addr8, bus_wdata8, mem_data_in8, if_data8}); end
    rst = 1'b0;
  endtask

  task automatic test_byte_load8();
    int k, b0;
    @(negedge clk);
    b0 = beats8;
    mem_req8 = 1'b1; mem_we8 = 1'b0; mem_addr8 = 8'h10; mem_acc_width8 = MEM_ACC_8;
    wait_rdy(2, 20, k);
    n_cmp++; if (k !== 2) begin n_bad++; $display("FAIL load8_latency: got %0d expected 2", k); end
    n_cmp++; if (mem_data_in8 !== 8'hA5) begin n_bad++; $display("FAIL load8_data: got %h expected a5", mem_data_in8); end
    n_cmp++; if (beats8 - b0 !== 1 || last_addr8 !== 8'h10 || last_we8 !== 1'b0) begin n_bad++; $display("FAIL load8_beat: got %0d beats addr %h we %b expected 1 beat addr 10 we 0", beats8 - b0, last_addr8, last_we8); end
    @(negedge clk); mem_req8 = 1'b0;
    repeat (2) @(negedge clk);
    // word store on an 8-bit client is clipped to a single beat
    b0 = beats8;
    mem_req8 = 1'b1; mem_we8 = 1'b1; mem_addr8 = 8'hFF; mem_data_out8 = 8'h7E; mem_acc_width8 = MEM_ACC_32;
    wait_rdy(2, 20, k);
    n_cmp++; if (k !== 2) begin n_bad++; $display("FAIL clip8_latency: got %0d expected 2", k); end
    n_cmp++; if (beats8 - b0 !== 1 || last_addr8 !== 8'hFF || last_wdata8 !== 8'h7E || last_we8 !== 1'b1) begin n_bad++; $display("FAIL clip8_beat: got %0d beats addr %h data %h we %b expected 1 beat ff 7e 1", beats8 - b0, last_addr8, last_wdata8, last_we8); end
    n_cmp++; if (mem_data_in8 !== 8'hA5) begin n_bad++; $display("FAIL clip8_rdata_hold: got %h expected a5", mem_data_in8); end
    @(negedge clk); mem_req8 = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_word_load();
    int k;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_acc_width = MEM_ACC_32;
    wait_rdy(0, 30, k);
    n_cmp++; if (k !== 5) begin n_bad++; $display("FAIL wload_latency: got %0d expected 5", k); end
    n_cmp++; if (mem_data_in !== 32'hEFBEADDE) begin n_bad++; $display("FAIL wload_data: got %h expected efbeadde", mem_data_in); end
    release_exec();
  endtask

  task automatic test_halfword_load();
    int k, b0;
    b0 = log_addr.size();
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_acc_width = MEM_ACC_16;
    wait_rdy(0, 30, k);
    n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL hload_latency: got %0d expected 3", k); end
    n_cmp++; if (mem_data_in !== 32'h00001234) begin n_bad++; $display("FAIL hload_data: got %h expected 00001234", mem_data_in); end
    n_cmp++; if (log_addr.size() - b0 !== 2) begin n_bad++; $display("FAIL hload_beats: got %0d expected 2", log_addr.size() - b0); end
    release_exec();
  endtask

  task automatic test_word_store();
    logic [31:0] exp_a [4];
    logic [7:0]  exp_d [4];
    int k, b0, r0, i, nb;
    exp_a[0] = 32'hFFFF_FFFE; exp_a[1] = 32'hFFFF_FFFF; exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0001;
    exp_d[0] = 8'h44; exp_d[1] = 8'h33; exp_d[2] = 8'h22; exp_d[3] = 8'h11;
    b0 = log_addr.size(); r0 = mem_rdy_cnt; wait32 = 2;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'hFFFF_FFFE; mem_data_out = 32'h11223344; mem_acc_width = MEM_ACC_32;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      i = log_addr.size() - b0;
      if (bus_req && i < 4) begin
        n_cmp++;
        if (bus_addr !== exp_a[i] || bus_wdata !== exp_d[i] || bus_we !== 1'b1) begin n_bad++; $display("FAIL store_beat_hold: cycle %0d beat %0d got addr %h data %h we %b expected addr %h data %h we 1", k, i, bus_addr, bus_wdata, bus_we, exp_a[i], exp_d[i]); end
      end
    end while (!mem_ready && k < 60);
    n_cmp++; if (k !== 13) begin n_bad++; $display("FAIL store_latency: got %0d expected 13", k); end
    nb = log_addr.size() - b0;
    n_cmp++; if (nb !== 4) begin n_bad++; $display("FAIL store_beats: got %0d expected 4", nb); end
    for (int j = 0; j < 4 && j < nb; j++) begin
      n_cmp++;
      if (log_addr[b0+j] !== exp_a[j] || log_wdata[b0+j] !== exp_d[j] || log_we[b0+j] !== 1'b1) begin n_bad++; $display("FAIL store_log%0d: got addr %h data %h we %b expected %h %h 1", j, log_addr[b0+j], log_wdata[b0+j], log_we[b0+j], exp_a[j], exp_d[j]); end
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (mem_rdy_cnt - r0 !== 1) begin n_bad++; $display("FAIL store_ready_count: got %0d expected 1", mem_rdy_cnt - r0); end
    n_cmp++; if (mem_data_in !== 32'h00001234) begin n_bad++; $display("FAIL store_rdata_hold: got %h expected 00001234", mem_data_in); end
    wait32 = 0;
    release_exec();
  endtask

  task automatic test_arbitration();
    int k, b0, r0;
    logic saw;
    b0 = log_addr.size(); r0 = if_rdy_cnt; saw = 1'b0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_acc_width = MEM_ACC_8;
    if_req = 1'b1; if_addr = 32'h400;
    wait_rdy(0, 20, k);
    n_cmp++; if (k !== 2) begin n_bad++; $display("FAIL arb_exec_latency: got %0d expected 2", k); end
    n_cmp++; if (if_rdy_cnt - r0 !== 0 || log_addr.size() - b0 !== 1 || log_addr[b0] !== 32'h300) begin n_bad++; $display("FAIL arb_exec_first: got if_ready %0d beats %0d expected 0 and 1 beat at 300", if_rdy_cnt - r0, log_addr.size() - b0); end
    repeat (2) begin @(negedge clk); if (bus_req) saw = 1'b1; end
    n_cmp++; if (saw !== 1'b0) begin n_bad++; $display("FAIL arb_release_hold: got bus_req %b expected 0", saw); end
    mem_req = 1'b0;
    wait_rdy(1, 20, k);
    n_cmp++; if (k !== 6) begin n_bad++; $display("FAIL arb_fetch_latency: got %0d expected 6", k); end
    n_cmp++; if (if_data !== 32'h04030201 || mem_data_in !== 32'h0000005A) begin n_bad++; $display("FAIL arb_data: got if %h mem %h expected 04030201 0000005a", if_data, mem_data_in); end
    n_cmp++; if (log_addr.size() - b0 !== 5 || log_addr[b0+1] !== 32'h400 || log_addr[b0+4] !== 32'h403) begin n_bad++; $display("FAIL arb_fetch_beats: got %0d beats expected 5 at 400..403", log_addr.size() - b0); end
    @(negedge clk); if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_hold_after_ready();
    int k, b0, r0;
    logic saw;
    b0 = log_addr.size(); r0 = mem_rdy_cnt; saw = 1'b0;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h300; mem_acc_width = MEM_ACC_8;
    wait_rdy(0, 20, k);
    n_cmp++; if (k !== 2) begin n_bad++; $display("FAIL hold_latency: got %0d expected 2", k); end
    repeat (5) begin @(negedge clk); if (bus_req) saw = 1'b1; end
    n_cmp++; if (mem_rdy_cnt - r0 !== 1 || log_addr.size() - b0 !== 1 || saw !== 1'b0) begin n_bad++; $display("FAIL hold_single: got %0d ready %0d beats bus_req %b expected 1 1 0", mem_rdy_cnt - r0, log_addr.size() - b0, saw); end
    mem_req = 1'b0; if_req = 1'b1; if_addr = 32'h400;
    @(negedge clk);
    n_cmp++; if (bus_req !== 1'b0) begin n_bad++; $display("FAIL hold_idle_gap: got bus_req %b expected 0", bus_req); end
    @(negedge clk);
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin n_bad++; $display("FAIL hold_next_grant: got bus_req %b addr %h expected 1 400", bus_req, bus_addr); end
    wait_rdy(1, 20, k);
    n_cmp++; if (k !== 4) begin n_bad++; $display("FAIL hold_next_ready: got %0d expected 4", k); end
    @(negedge clk); if_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int k, b0, r0;
    b0 = log_addr.size();
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200; mem_acc_width = MEM_ACC_32;
    repeat (2) @(negedge clk);
    n_cmp++; if (log_addr.size() - b0 !== 1 || bus_req !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got %0d beats bus_req %b expected 1 1", log_addr.size() - b0, bus_req); end
    rst = 1'b1; mem_req = 1'b0; r0 = mem_rdy_cnt;
    @(negedge clk);
    n_cmp++; if ({bus_req, bus_we, mem_ready, if_ready, bus_addr, bus_wdata, mem_data_in, if_data} !== 108'h0) begin n_bad++; $display("FAIL rstmid_outputs: got req %b addr %h rdata %h expected all 0", bus_req, bus_addr, mem_data_in); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (mem_rdy_cnt !== r0 || log_addr.size() - b0 !== 1) begin n_bad++; $display("FAIL rstmid_abandon: got %0d ready %0d beats expected 0 1", mem_rdy_cnt - r0, log_addr.size() - b0); end
    mem_req = 1'b1; mem_addr = 32'h100; mem_acc_width = MEM_ACC_16;
    wait_rdy(0, 20, k);
    n_cmp++; if (k !== 3 || mem_data_in !== 32'h00001234) begin n_bad++; $display("FAIL rstmid_recover: got latency %0d data %h expected 3 00001234", k, mem_data_in); end
    release_exec();
  endtask

  initial begin
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_data_out = '0; mem_acc_width = MEM_ACC_8;
    if_req = 1'b0; if_addr = '0;
    mem_req8 = 1'b0; mem_we8 = 1'b0; mem_addr8 = '0; mem_data_out8 = '0; mem_acc_width8 = MEM_ACC_8;
    if_req8 = 1'b0; if_addr8 = '0;
    mem32[32'h100] = 8'h34; mem32[32'h101] = 8'h12;
    mem32[32'h200] = 8'hDE; mem32[32'h201] = 8'hAD; mem32[32'h202] = 8'hBE; mem32[32'h203] = 8'hEF;
    mem32[32'h300] = 8'h5A;
    mem32[32'h400] = 8'h01; mem32[32'h401] = 8'h02; mem32[32'h402] = 8'h03; mem32[32'h403] = 8'h04;
    test_reset();
    test_byte_load8();
    test_word_load();
    test_halfword_load();
    test_word_store();
    test_arbitration();
    test_hold_after_ready();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
